// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: state encoding and defaults for the instruction memory loader
package imem_loader_pkg;
  typedef enum logic [2:0] {IDLE, LEN, DATA, WRITE, CHK, DONE} state_t;
  localparam int MAX_WORDS_DEF = 64;
endpackage

// File: rtl/imem_loader_byte_assembler.sv
// imem_loader_byte_assembler: little-endian word assembly with running XOR checksum
module imem_loader_byte_assembler (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        en,
  input  logic [7:0]  din,
  output logic [31:0] word_next,
  output logic [7:0]  xsum,
  output logic        word_full
);
  logic [31:0] word;
  logic [1:0]  cnt;
  assign word_full = en && cnt == 2'd3;
  always_comb begin
    word_next = word;
    word_next[cnt*8 +: 8] = din;
  end
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      word <= '0;
      cnt  <= '0;
      xsum <= '0;
    end else if (en) begin
      word <= word_next;
      cnt  <= cnt + 2'd1;
      xsum <= xsum ^ din;
    end
  end
endmodule

// File: rtl/imem_loader.sv
// imem_loader: loads a length-prefixed, XOR-checked byte stream into instruction RAM
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int              ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int              MAX_WORDS = MAX_WORDS_DEF
) (
  input  logic              CLK,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic              err
);
  localparam int IW = $clog2(MAX_WORDS + 1);
  state_t        state;
  logic [IW-1:0] n, idx, idx_inc;
  logic          we_q, xfer, clear, en, word_full;
  logic [31:0]   word_next;
  logic [7:0]    xsum;
  assign xfer    = in_valid && in_ready;
  assign clear   = state == IDLE && start;
  assign en      = state == DATA && xfer;
  assign idx_inc = idx + IW'(1);
  // The strobe is gated so a write can never coincide with reset.
  assign mem_we  = we_q & ~rst;
  imem_loader_byte_assembler u_asm (
    .clk(CLK), .rst(rst), .clear(clear), .en(en), .din(in_data),
    .word_next(word_next), .xsum(xsum), .word_full(word_full)
  );
  always_ff @(posedge CLK) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      we_q      <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_rst   <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      n         <= '0;
      idx       <= '0;
    end else begin
      we_q <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state    <= LEN;
          in_ready <= 1'b1;
          busy     <= 1'b1;
          cpu_rst  <= 1'b1;
          err      <= 1'b0;
          idx      <= '0;
        end
        LEN: if (xfer) begin
          n <= IW'(in_data);
          if (in_data == 8'd0) state <= CHK;
          else if (32'(in_data) > MAX_WORDS) begin
            state    <= IDLE;
            err      <= 1'b1;
            in_ready <= 1'b0;
            busy     <= 1'b0;
          end else state <= DATA;
        end
        DATA: if (word_full) begin
          state     <= WRITE;
          in_ready  <= 1'b0;
          we_q      <= 1'b1;
          mem_addr  <= BASE_ADDR + ADDR_W'({idx, 2'b00});
          mem_wdata <= word_next;
        end
        WRITE: begin
          idx      <= idx_inc;
          in_ready <= 1'b1;
          state    <= idx_inc == n ? CHK : DATA;
        end
        CHK: if (xfer) begin
          in_ready <= 1'b0;
          if (in_data == xsum) begin
            state   <= DONE;
            done    <= 1'b1;
            cpu_rst <= 1'b0;
          end else begin
            state <= IDLE;
            err   <= 1'b1;
            busy  <= 1'b0;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed self-checking bench for imem_loader
module tb_imem_loader;
  logic       CLK = 0, rst = 1, start = 0, in_valid = 0;
  logic [7:0] in_data = 0;
  logic       in_ready, mem_we, cpu_rst, busy, done, err;
  logic [7:0] mem_addr;
  logic [31:0] mem_wdata;
  int checks = 0, errors = 0, we_cnt = 0, done_cnt = 0;
  logic [7:0]  wa [4];
  logic [31:0] wd [4];
  logic [7:0] nominal [10] = '{8'h02, 8'h93, 8'h06, 8'h45, 8'h00, 8'h13, 8'h07, 8'h10, 8'h00, 8'hD4};
  int gaps [10] = '{1, 0, 2, 0, 3, 1, 0, 2, 1, 2};

  imem_loader dut (
    .CLK(CLK), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_rst(cpu_rst), .busy(busy), .done(done), .err(err)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (rst) check("we_in_rst", {31'b0, mem_we}, 0);
    if (mem_we) begin
      check("rdy_in_write", {31'b0, in_ready}, 0);
      if (we_cnt < 4) begin
        wa[we_cnt] = mem_addr;
        wd[we_cnt] = mem_wdata;
      end
      we_cnt++;
    end
    if (done) done_cnt++;
  end

  task automatic clear_log();
    we_cnt = 0;
    done_cnt = 0;
  endtask

  task automatic do_start();
    start = 1;
    @(posedge CLK); #1;
    start = 0;
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    int t = 0;
    repeat (gap) begin @(posedge CLK); #1; end
    in_valid = 1;
    in_data = b;
    do begin @(negedge CLK); t++; end while (!in_ready && t < 50);
    if (t >= 50) check("send_timeout", 1, 0);
    @(posedge CLK); #1;
    in_valid = 0;
  endtask

  task automatic wait_idle();
    int t = 0;
    do begin @(negedge CLK); t++; end while (busy && t < 200);
    if (t >= 200) check("idle_timeout", 1, 0);
    @(posedge CLK); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    @(negedge CLK);
    check({tag, "_rdy"}, {31'b0, in_ready}, 0);
    check({tag, "_we"}, {31'b0, mem_we}, 0);
    check({tag, "_addr"}, {24'b0, mem_addr}, 0);
    check({tag, "_wdata"}, mem_wdata, 0);
    check({tag, "_cpurst"}, {31'b0, cpu_rst}, 1);
    check({tag, "_busy"}, {31'b0, busy}, 0);
    check({tag, "_done"}, {31'b0, done}, 0);
    check({tag, "_err"}, {31'b0, err}, 0);
    @(posedge CLK); #1;
  endtask

  task automatic check_nominal_writes(input string tag);
    check({tag, "_wecnt"}, we_cnt, 2);
    check({tag, "_a0"}, {24'b0, wa[0]}, 32'h00);
    check({tag, "_d0"}, wd[0], 32'h00450693);
    check({tag, "_a1"}, {24'b0, wa[1]}, 32'h04);
    check({tag, "_d1"}, wd[1], 32'h00100713);
  endtask

  task automatic check_success(input string tag);
    check({tag, "_done"}, done_cnt, 1);
    check({tag, "_cpurst"}, {31'b0, cpu_rst}, 0);
    check({tag, "_err"}, {31'b0, err}, 0);
    check({tag, "_busy"}, {31'b0, busy}, 0);
  endtask

  initial begin
    repeat (2) @(posedge CLK);
    #1 rst = 0;
    check_reset_outputs("reset");

    clear_log();
    do_start();
    for (int i = 0; i < 10; i++) send(nominal[i], 0);
    wait_idle();
    check_nominal_writes("nom");
    check_success("nom");

    clear_log();
    do_start();
    send(8'h00, 0);
    send(8'h00, 0);
    wait_idle();
    check("empty_wecnt", we_cnt, 0);
    check_success("empty");

    clear_log();
    do_start();
    send(8'h41, 0);
    wait_idle();
    @(negedge CLK);
    check("over_err", {31'b0, err}, 1);
    check("over_wecnt", we_cnt, 0);
    check("over_cpurst", {31'b0, cpu_rst}, 1);
    check("over_busy", {31'b0, busy}, 0);
    check("over_rdy", {31'b0, in_ready}, 0);
    check("over_done", done_cnt, 0);
    @(posedge CLK); #1;

    clear_log();
    do_start();
    @(negedge CLK);
    check("start_clears_err", {31'b0, err}, 0);
    @(posedge CLK); #1;
    for (int i = 0; i < 9; i++) send(nominal[i], 0);
    send(8'hD5, 0);
    wait_idle();
    check_nominal_writes("badck");
    check("badck_err", {31'b0, err}, 1);
    check("badck_done", done_cnt, 0);
    check("badck_cpurst", {31'b0, cpu_rst}, 1);

    clear_log();
    do_start();
    for (int i = 0; i < 10; i++) begin
      send(nominal[i], gaps[i]);
      if (i == 3) do_start();
    end
    wait_idle();
    check_nominal_writes("gaps");
    check_success("gaps");

    clear_log();
    do_start();
    for (int i = 0; i < 3; i++) send(nominal[i], 0);
    rst = 1;
    @(posedge CLK); #1;
    rst = 0;
    check_reset_outputs("midrst");
    repeat (20) @(posedge CLK);
    #1;
    check("midrst_wecnt", we_cnt, 0);
    check("midrst_done", done_cnt, 0);

    clear_log();
    do_start();
    for (int i = 0; i < 10; i++) send(nominal[i], 0);
    wait_idle();
    check_nominal_writes("after_rst");
    check_success("after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Writer side of the instruction memory that the fetch path reads. It takes a byte stream from a host link, assembles little-endian 32-bit instruction words, and writes them to consecutive word addresses of the instruction RAM. It holds the CPU in reset until a complete, checksum-verified program has been written.

Parameters:
ADDR_W, 8, instruction memory byte-address width; must match the PC width.
BASE_ADDR, 8'h00, byte address of the first word written.
MAX_WORDS, 64, largest accepted word count; requires BASE_ADDR + 4*MAX_WORDS <= 2**ADDR_W.

Ports:
CLK  input  1  clock; all state updates on the posedge.
rst  input  1  synchronous, active-high reset.
start  input  1  begin a load session; sampled only in IDLE.
in_valid  input  1  host byte valid.
in_data  input  8  host byte.
in_ready  output  1  loader accepts a byte this cycle; transfer occurs when in_valid and in_ready are both 1.
mem_we  output  1  instruction RAM write strobe, one cycle per word.
mem_addr  output  ADDR_W  byte address of the word being written (word aligned).
mem_wdata  output  32  instruction word.
cpu_rst  output  1  reset request to PC/CPU; 1 = hold the CPU in reset.
busy  output  1  session in progress (any state other than IDLE).
done  output  1  one-cycle pulse on successful load.
err  output  1  sticky error flag for the last session; cleared by start.

Behaviour:
- Reset values: state IDLE; in_ready=0; mem_we=0; mem_addr=0; mem_wdata=0; cpu_rst=1; busy=0; done=0; err=0. All internal counters, the assembled word, and the XOR accumulator are 0.
- Frame format: length byte N (word count), then 4*N data bytes (byte0 goes to bits[7:0]), then one checksum byte. The checksum is the XOR of all data bytes; the length byte is excluded.
- IDLE: in_ready=0. When start=1, go to LEN. On that transition: busy=1, cpu_rst=1, err=0, word index=0, XOR=0. start is ignored in every other state.
- LEN: in_ready=1. On a transfer, latch N:
  - N=0 -> CHK.
  - N>MAX_WORDS -> set err=1 and go to IDLE. No writes occur and cpu_rst stays 1.
  - Otherwise -> DATA with byte_cnt=0.
- DATA: in_ready=1. Each transfer places in_data in byte lane byte_cnt, XORs it into the accumulator, and increments byte_cnt. The transfer with byte_cnt=3 goes to WRITE. Cycles with in_valid=0 change nothing.
- WRITE: in_ready=0. mem_we=1 for exactly this cycle, with mem_addr=BASE_ADDR+4*idx and mem_wdata=the assembled word. Then increment idx. If the new idx equals N -> CHK, else -> DATA.
- CHK: in_ready=1. On a transfer:
  - in_data equals the accumulator -> DONE.
  - Otherwise -> set err=1 and go to IDLE with cpu_rst=1. Words already written remain in memory.
- DONE: done=1 for one cycle, cpu_rst=0, then go to IDLE. cpu_rst stays 0 until the next start.
- mem_addr/mem_wdata hold their last values when mem_we=0.
- Throughput: at least 5 cycles per word (4 byte transfers plus 1 write cycle).
- Reset mid-session: synchronous return to reset values on the cycle rst is sampled high. mem_we is never asserted while rst=1. Partially written memory is not scrubbed.
- Index arithmetic is unsigned, at least clog2(MAX_WORDS+1) bits wide. There is no wrap, because N is bounded by MAX_WORDS.

Decomposition:
- Shared package: state encoding constants (IDLE, LEN, DATA, WRITE, CHK, DONE) and the default MAX_WORDS.
- Sub-module byte_assembler: 32-bit lane-shift register, 2-bit byte counter, XOR accumulator. It has a clear input and outputs word_full and the assembled word. The FSM, address generation and handshake stay in imem_loader.

Test Plan:
- Nominal load: start; bytes 02, 93 06 45 00, 13 07 10 00, D4.
  - Expect writes (0x00, 0x00450693) then (0x04, 0x00100713).
  - Expect a done pulse, then cpu_rst=0, err=0, busy=0.
- Empty program: start; bytes 00, 00 -> no mem_we; done pulses; cpu_rst=0.
- Oversize: start; byte 41 (65) -> err=1, no mem_we, cpu_rst=1, back in IDLE, in_ready=0.
- Bad checksum: the nominal frame with final byte D5.
  - Both words are still written.
  - Then err=1, no done pulse, cpu_rst=1.
- Backpressure/gaps: the nominal frame with random in_valid gaps.
  - Identical writes and done.
  - in_ready=0 during WRITE; no byte is lost or duplicated.
- Reset and ignored start:
  - Assert rst after the 2nd data byte -> all outputs return to reset values and no further mem_we occurs.
  - A start pulse during DATA is ignored.
